// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard/stall sequencing block.
package hazard_pkg;

  localparam int REG_ADDR_W      = 4;
  localparam int MEM_TIMEOUT_DEF = 200;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_stall_controller_detect.sv
// RAW hazard detection between ID and the EXE/MEM producers.
// Build option FORWARDING_EN: only load-use hazards stall; otherwise any EXE/MEM match stalls.
module hazard_detect #(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] i_id_src1,
  input  logic [REG_ADDR_W-1:0] i_id_src2,
  input  logic                  i_id_two_src,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_exe_dest,
  input  logic                  i_exe_wb_en,
  input  logic                  i_exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] i_mem_dest,
  input  logic                  i_mem_wb_en,
  output logic                  o_raw_stall
);

  logic w_m_exe;
  logic w_m_mem;
  logic w_load_use;

  // Match ID sources against the in-flight destinations and pick the stall rule.
  always_comb begin
    w_m_exe     = 1'b0;
    w_m_mem     = 1'b0;
    w_load_use  = 1'b0;
    o_raw_stall = 1'b0;
    if (i_id_valid) begin
      w_m_exe = i_exe_wb_en & ((i_id_src1 == i_exe_dest) |
                               (i_id_two_src & (i_id_src2 == i_exe_dest)));
      w_m_mem = i_mem_wb_en & ((i_id_src1 == i_mem_dest) |
                               (i_id_two_src & (i_id_src2 == i_mem_dest)));
    end else begin
      w_m_exe = 1'b0;
      w_m_mem = 1'b0;
    end
    w_load_use = w_m_exe & i_exe_mem_r_en;
`ifdef FORWARDING_EN
    o_raw_stall = w_load_use;
`else
    // load-use is a subset of m_exe, so OR-ing it in changes nothing
    o_raw_stall = w_m_exe | w_m_mem | w_load_use;
`endif
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush/freeze sequencing with memory-wait timeout and stall counter.
// Build option FORWARDING_EN selects load-use-only stalling in hazard_detect.
module hazard_stall_controller #(
  parameter int REG_ADDR_W  = hazard_pkg::REG_ADDR_W,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = hazard_pkg::MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  freeze_pc,
  output logic                  freeze_if_id,
  output logic                  bubble_id_exe,
  output logic                  flush_if_id,
  output logic                  freeze_all,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt
);

  import hazard_pkg::*;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMO_W-1:0] r_wait_cnt;
  logic [TMO_W-1:0] w_wait_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_mem_err;
  logic             w_raw_stall;
  logic             w_mem_wait;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
    .i_id_src1      (id_src1),
    .i_id_src2      (id_src2),
    .i_id_two_src   (id_two_src),
    .i_id_valid     (id_valid),
    .i_exe_dest     (exe_dest),
    .i_exe_wb_en    (exe_wb_en),
    .i_exe_mem_r_en (exe_mem_r_en),
    .i_mem_dest     (mem_dest),
    .i_mem_wb_en    (mem_wb_en),
    .o_raw_stall    (w_raw_stall)
  );

  assign w_mem_wait = mem_req & ~mem_ready;

  // Memory-wait FSM next state; a ready on the timeout cycle still returns to RUN.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (w_mem_wait) begin
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = TMO_W'(1);
        end else begin
          w_wait_cnt_nxt = {TMO_W{1'b0}};
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = {TMO_W{1'b0}};
        end else if (r_wait_cnt == TMO_LAST) begin
          w_state_nxt = MEM_ERR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + TMO_W'(1);
        end
      end
      MEM_ERR: begin
        w_state_nxt = MEM_ERR;
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = {TMO_W{1'b0}};
      end
    endcase
  end

  // Priority mux: memory freeze, then branch flush, then RAW stall.
  always_comb begin
    freeze_pc     = 1'b0;
    freeze_if_id  = 1'b0;
    bubble_id_exe = 1'b0;
    flush_if_id   = 1'b0;
    freeze_all    = 1'b0;
    if (rst) begin
      freeze_all = 1'b0;
    end else if ((r_state == MEM_ERR) || w_mem_wait) begin
      freeze_all = 1'b1;
    end else if (branch_taken) begin
      flush_if_id   = 1'b1;
      bubble_id_exe = 1'b1;
    end else if (w_raw_stall) begin
      freeze_pc     = 1'b1;
      freeze_if_id  = 1'b1;
      bubble_id_exe = 1'b1;
    end else begin
      freeze_all = 1'b0;
    end
  end

  // State, wait counter, sticky error flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= {TMO_W{1'b0}};
      r_stall_cnt <= {CNT_W{1'b0}};
      r_mem_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= r_mem_err | (w_state_nxt == MEM_ERR);
      if ((freeze_all | freeze_pc) && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;

endmodule
